// File: rtl/pmem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one 64-bit, 4-beat burst memory port.
// One line transaction is in flight at a time; a tie alternates grants so neither cache starves.
module pmem_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [63:0]  pmem_wdata,
    input  logic [63:0]  pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic           last_d_q, last_d_d;
    logic           grant_d_q, grant_d_d;
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   wline_q, wline_d;
    logic [255:0]   rbuf_q, rbuf_d;
    logic [255:0]   i_rdata_q, i_rdata_d;
    logic [255:0]   d_rdata_q, d_rdata_d;
    logic [255:0]   line_next;
    logic           d_req;

    assign d_req = d_read | d_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= 2'd0;
            last_d_q  <= 1'b0;
            grant_d_q <= 1'b0;
            addr_q    <= 32'd0;
            wline_q   <= 256'd0;
            rbuf_q    <= 256'd0;
            i_rdata_q <= 256'd0;
            d_rdata_q <= 256'd0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            last_d_q  <= last_d_d;
            grant_d_q <= grant_d_d;
            addr_q    <= addr_d;
            wline_q   <= wline_d;
            rbuf_q    <= rbuf_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        last_d_d  = last_d_q;
        grant_d_d = grant_d_q;
        addr_d    = addr_q;
        wline_d   = wline_q;
        rbuf_d    = rbuf_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        line_next = rbuf_q;
        line_next[{beat_q, 6'd0} +: 64] = pmem_rdata;

        case (state_q)
            IDLE: begin
                // D wins a tie unless it also won the previous grant.
                if (d_req && (!i_read || !last_d_q)) begin
                    grant_d_d = 1'b1;
                    last_d_d  = 1'b1;
                    addr_d    = {d_address[31:5], 5'd0};
                    wline_d   = d_wdata;
                    beat_d    = 2'd0;
                    state_d   = d_write ? D_WR : D_RD;
                end else if (i_read) begin
                    grant_d_d = 1'b0;
                    last_d_d  = 1'b0;
                    addr_d    = {i_address[31:5], 5'd0};
                    beat_d    = 2'd0;
                    state_d   = I_RD;
                end
            end
            I_RD, D_RD: begin
                if (pmem_resp) begin
                    rbuf_d = line_next;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                        if (state_q == I_RD) i_rdata_d = line_next;
                        else                 d_rdata_d = line_next;
                    end
                end
            end
            D_WR: begin
                if (pmem_resp) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pmem_read    = (state_q == I_RD) || (state_q == D_RD);
    assign pmem_write   = (state_q == D_WR);
    assign pmem_address = addr_q;
    assign pmem_wdata   = (state_q == D_WR) ? wline_q[{beat_q, 6'd0} +: 64] : 64'd0;
    assign i_resp       = (state_q == DONE) && !grant_d_q;
    assign d_resp       = (state_q == DONE) && grant_d_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;

endmodule
